// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with 2-flop synchroniser, byte FIFO and valid/ready read port.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overflow,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          pbad, pbad_n;
    logic          rx_m, rx_s, rx_p;
    logic          push, ferr;
`ifdef UART_RX_PARITY_EN
    logic          perr;
`endif

    // rx_p is one cycle older than rx_s, for start-edge detection
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            pbad        <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            pbad        <= pbad_n;
            framing_err <= ferr;
`ifdef UART_RX_PARITY_EN
            parity_err  <= perr;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        pbad_n  = pbad;
        push    = 1'b0;
        ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr    = 1'b0;
`endif
        case (state)
            IDLE: if (rx_p && !rx_s) begin
                state_n = START;
                cnt_n   = HALF;
            end
            START: if (cnt == '0) begin
                cnt_n   = FULL;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end else cnt_n = cnt - 1'b1;
            DATA: if (cnt == '0) begin
                shift_n[idx] = rx_s;
                cnt_n        = FULL;
                idx_n        = idx + 1'b1;
                if (idx == 3'd7) begin
                    pbad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end else cnt_n = cnt - 1'b1;
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == '0) begin
                perr    = ^{shift, rx_s};
                pbad_n  = perr;
                cnt_n   = FULL;
                state_n = STOP;
            end else cnt_n = cnt - 1'b1;
`endif
            STOP: if (cnt == '0) begin
                if (rx_s) begin
                    push    = !pbad;
                    state_n = IDLE;
                end else begin
                    ferr    = 1'b1;
                    state_n = BREAK;
                end
            end else cnt_n = cnt - 1'b1;
            // held-low line: no new frame until the line returns high
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // FIFO: pointers carry an extra wrap bit to tell full from empty
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full, pop, do_wr;

    assign rd_valid   = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rd_valid && rd_ready;
    assign do_wr      = push && (!full || pop);
    assign fifo_count = wr_ptr - rd_ptr;
    assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overflow <= push && full && !pop;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= shift;
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 16 clocks/bit with a 4-entry FIFO.
module tb_uart_rx_monitor;
    localparam int CPB = 16;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       framing_err, overflow, busy;

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .resetb(resetb), .rx(rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .framing_err(framing_err),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    int         n_vec = 0, n_err = 0;
    int         vcyc = 0, ferr_n = 0, ovf_n = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] got_q [$];

    always @(negedge clock) begin
        if (rd_valid && rd_ready) got_q.push_back(rd_data);
        if (rd_valid) vcyc++;
        if (framing_err) ferr_n++;
        if (overflow) ovf_n++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        cyc(CPB);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
    endtask

    task automatic clr();
        vcyc = 0; ferr_n = 0; ovf_n = 0; busy_seen = 1'b0;
        got_q.delete();
    endtask

    task automatic chk_q(input string tag, input logic [7:0] e0, e1, e2, e3, input int n);
        logic [7:0] exp [4];
        exp = '{e0, e1, e2, e3};
        chk({tag, "_size"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            chk(tag, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hdead, {24'h0, exp[i]});
    endtask

    initial begin
        cyc(4);
        resetb = 1'b1;
        cyc(4);
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rd_data, 8'h00);

        // single byte
        rd_ready = 1'b1;
        clr();
        send(8'h4D, 1'b1);
        cyc(20);
        chk("single_vcyc", vcyc, 1);
        chk_q("single_byte", 8'h4D, 0, 0, 0, 1);
        chk("single_ferr", ferr_n, 0);
        chk("single_ovf", ovf_n, 0);

        // glitch shorter than half a bit
        clr();
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        cyc(30);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_vcyc", vcyc, 0);
        chk("glitch_ferr", ferr_n, 0);

        // framing error, held-low break, then recovery
        clr();
        send(8'hA5, 1'b0);
        rx = 1'b0;
        cyc(40);
        chk("break_ferr", ferr_n, 1);
        chk("break_count", fifo_count, 0);
        chk("break_busy", busy, 1);
        chk("break_vcyc", vcyc, 0);
        rx = 1'b1;
        cyc(20);
        chk("break_idle", busy, 0);
        send(8'h3C, 1'b1);
        cyc(10);
        chk_q("recover", 8'h3C, 0, 0, 0, 1);
        chk("recover_ferr", ferr_n, 1);

        // overflow on the fifth byte
        clr();
        rd_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send(8'(b), 1'b1);
        chk("ovf_count4", fifo_count, 4);
        chk("ovf_none_yet", ovf_n, 0);
        send(8'h05, 1'b1);
        chk("ovf_pulse", ovf_n, 1);
        chk("ovf_count_held", fifo_count, 4);
        rd_ready = 1'b1;
        cyc(10);
        chk_q("ovf_drain", 8'h01, 8'h02, 8'h03, 8'h04, 4);

        // push and pop on the same edge while full
        clr();
        rd_ready = 1'b0;
        for (int b = 0; b < 4; b++) send(8'h10 + 8'(b), 1'b1);
        chk("sim_full", fifo_count, 4);
        fork
            send(8'h14, 1'b1);
            begin
                cyc(154);
                rd_ready = 1'b1;
                cyc(1);
                rd_ready = 1'b0;
            end
        join
        cyc(5);
        chk("sim_ovf", ovf_n, 0);
        chk("sim_count", fifo_count, 4);
        got_q.delete();
        rd_ready = 1'b1;
        cyc(10);
        chk_q("sim_drain", 8'h11, 8'h12, 8'h13, 8'h14, 4);

        // reset in the middle of a frame flushes the FIFO
        clr();
        rd_ready = 1'b0;
        send(8'h77, 1'b1);
        chk("mid_pre_count", fifo_count, 1);
        fork
            send(8'hFF, 1'b1);
            begin
                cyc(70);
                resetb = 1'b0;
                cyc(1);
                chk("mid_rst_valid", rd_valid, 0);
                chk("mid_rst_count", fifo_count, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_data", rd_data, 8'h00);
                cyc(47);
                resetb = 1'b1;
            end
        join
        cyc(20);
        chk("mid_post_count", fifo_count, 0);
        chk("mid_post_busy", busy, 0);
        got_q.delete();
        rd_ready = 1'b1;
        send(8'h55, 1'b1);
        cyc(10);
        chk_q("mid_next", 8'h55, 0, 0, 0, 1);
        chk("mid_ferr", ferr_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Serial receiver that decodes the Microwatt UART transmit line (mprj_io[6]) into a byte stream for the simulation and bring-up harness. It sits directly downstream of the Caravel top-level UART pin. It synchronises the line, frames 8N1 characters, buffers them in a small FIFO and presents them on a valid/ready interface. Consumers include a console logger and the pass/fail string matcher.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit, giving 115200 baud at 100 MHz; must be ≥ 4.
- FIFO_DEPTH, 16: byte FIFO entries; must be a power of two, ≥ 2.

Ports:
- clock  in  1  single clock; all state is on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clock.
- rd_data  out  8  head-of-FIFO byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the byte; a pop occurs when rd_valid & rd_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- framing_err  out  1  one-cycle pulse when the stop bit samples low.
- overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy  out  1  receiver FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser; the reset value of both flops is 1. All FSM decisions use the synchronised value rx_s.
- FSM states and transitions:
  - IDLE: a falling edge of rx_s (previous 1, now 0) loads the bit counter with CLKS_PER_BIT/2 − 1 and moves to START.
  - START: when the counter expires, sample rx_s. If 0, move to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE; nothing is logged.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx], LSB first. After idx 7, move to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1, push the byte and return to IDLE.
    - If 0, pulse framing_err, discard the byte and move to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing spurious characters.
- FIFO rules:
  - Circular buffer; pointers are one bit wider than the index so full and empty are distinguishable.
  - Push when full: the byte is dropped, overflow pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle are both performed, including when full, so nothing is dropped.
  - Pop when empty is ignored.
- Reset values: rd_valid=0, fifo_count=0, framing_err=0, overflow=0, busy=0, rd_data=8'h00, FSM=IDLE, pointers=0.
- Asserting resetb low mid-character aborts it immediately and flushes the FIFO. After release, the FSM waits in IDLE for a new falling edge; it does not resynchronise onto the remainder of the aborted frame.

## Timing
- Sampling points, measured from the rx_s falling edge:
  - Start bit checked at CLKS_PER_BIT/2 cycles (integer division).
  - Data bit n sampled at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT.
  - Stop bit sampled at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The push happens on the stop-sample edge. rd_valid and fifo_count update on the following edge, so rd_data is visible one cycle after the stop sample.
- framing_err and overflow assert on the cycle after the stop sample and last exactly one cycle.
- Pin-to-rx_s latency is 2 cycles.
- Back-to-back characters: the FSM is in IDLE from mid-stop-bit onward, so it can accept a start edge 0.5 bit after the stop sample.
- Pop is combinational-ready: the next FIFO entry appears on rd_data the cycle after the pop edge.

## Configuration
- UART_RX_PARITY_EN: when defined, the frame is 8E1.
  - A PARITY state between DATA and STOP samples one extra bit.
  - The stop sample moves to CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
  - An added port parity_err (out, 1) pulses for one cycle when the XOR of the 8 data bits and the parity bit is 1. The byte is then discarded and the FSM goes to STOP as normal.
  - If both a parity error and a framing error occur, both pulse.
- When undefined: 8N1, no PARITY state, and the parity_err port is absent.

## Test plan
- Use CLKS_PER_BIT=16, FIFO_DEPTH=4 for all scenarios.
- Single byte: send 0x4D in 8N1 with rd_ready=1. Expect rd_valid for exactly 1 cycle with rd_data=0x4D, and no error pulses.
- Glitch rejection: drive rx low for 5 cycles, then high. Expect busy to rise and then return to 0, with no push and no errors.
- Framing error and break: send 0xA5 with the stop bit held low, and keep rx low for 40 cycles. Expect framing_err to pulse once, FIFO empty, and no further activity until rx goes high. Then send 0x3C and expect 0x3C to be received.
- Overflow: with rd_ready=0, send 0x01 to 0x05. Expect fifo_count=4 after the fourth byte and one overflow pulse on the fifth. Draining yields 0x01, 0x02, 0x03, 0x04.
- Simultaneous push and pop at full: hold the FIFO full with 0x10 to 0x13. Pulse rd_ready exactly on the 0x14 push edge. Expect no overflow, fifo_count stays 4, and the drain order is 0x11, 0x12, 0x13, 0x14.
- Reset mid-frame: assert resetb low during data bit 3 of 0xFF, and release it during bit 6. Expect outputs at reset values, no byte from the partial frame, and a following 0x55 received correctly.
